node_tx: RTL and testbench

NODE_TX -- requirements
Module: node_tx

---
 rtl/node_tx.sv | 169 ++++++++++++++++
 tb/tb_node_tx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/node_tx.sv
// Bus transmitter node: arbitrates for the daisy-chained bus, shifts bytes out MSB first,
// sends the end-of-message pattern, checks the downstream acknowledge and waits for bus idle.
module node_tx #(
  parameter int unsigned ARB_CYCLES  = 8,
  parameter int unsigned IDLE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       DIN,
  output logic       DOUT,
  input  logic       TX_REQ,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  input  logic       TX_LAST,
  output logic       TX_ACK,
  output logic       TX_DONE,
  output logic       TX_FAIL,
  output logic       BUSY
);

  localparam int unsigned ARB_W  = (ARB_CYCLES  > 1) ? $clog2(ARB_CYCLES)  : 1;
  localparam int unsigned IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned PAT_W  = 2;

  // End-of-message pattern indexed by the pattern counter: 0,1,1,0
  localparam logic [3:0] EOM_PATTERN = 4'b0110;
  localparam logic [2:0] ACK_GOOD    = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARB       = 3'd1,
    S_DATA      = 3'd2,
    S_EOM       = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t             state;
  logic [ARB_W-1:0]   arb_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [PAT_W-1:0]   pat_cnt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [7:0]         shift_q;
  logic               last_q;
  logic [1:0]         ack_hist;

  // Control FSM with registered handshake pulses
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      arb_cnt  <= '0;
      bit_cnt  <= '0;
      pat_cnt  <= '0;
      idle_cnt <= '0;
      shift_q  <= '0;
      last_q   <= 1'b0;
      ack_hist <= '0;
      TX_ACK   <= 1'b0;
      TX_DONE  <= 1'b0;
      TX_FAIL  <= 1'b0;
    end else begin
      TX_ACK  <= 1'b0;
      TX_DONE <= 1'b0;
      TX_FAIL <= 1'b0;

      case (state)
        S_IDLE: begin
          // A request while the bus is busy upstream (DIN low) is not honoured
          if (TX_REQ && DIN) begin
            state   <= S_ARB;
            arb_cnt <= ARB_W'(ARB_CYCLES - 1);
          end
        end

        S_ARB: begin
          if (arb_cnt != '0) begin
            arb_cnt <= arb_cnt - 1'b1;
          end else if (!DIN) begin
            TX_FAIL  <= 1'b1;
            idle_cnt <= '0;
            state    <= S_WAIT_IDLE;
          end else if (TX_VALID) begin
            shift_q <= TX_DATA;
            last_q  <= TX_LAST;
            bit_cnt <= BIT_W'(7);
            TX_ACK  <= 1'b1;
            state   <= S_DATA;
          end else begin
            TX_FAIL <= 1'b1;
            pat_cnt <= '0;
            state   <= S_EOM;
          end
        end

        S_DATA: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else if (last_q) begin
            pat_cnt <= '0;
            state   <= S_EOM;
          end else if (TX_VALID) begin
            shift_q <= TX_DATA;
            last_q  <= TX_LAST;
            bit_cnt <= BIT_W'(7);
            TX_ACK  <= 1'b1;
          end else begin
            TX_FAIL <= 1'b1;
            pat_cnt <= '0;
            state   <= S_EOM;
          end
        end

        S_EOM: begin
          if (pat_cnt == PAT_W'(3)) begin
            pat_cnt <= '0;
            state   <= S_ACK;
          end else begin
            pat_cnt <= pat_cnt + 1'b1;
          end
        end

        S_ACK: begin
          // The pattern counter doubles as the acknowledge sample counter
          ack_hist <= {ack_hist[0], DIN};
          if (pat_cnt == PAT_W'(2)) begin
            if ({ack_hist, DIN} == ACK_GOOD) begin
              TX_DONE <= 1'b1;
            end else begin
              TX_FAIL <= 1'b1;
            end
            pat_cnt  <= '0;
            idle_cnt <= '0;
            state    <= S_WAIT_IDLE;
          end else begin
            pat_cnt <= pat_cnt + 1'b1;
          end
        end

        S_WAIT_IDLE: begin
          if (!DIN) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_W'(IDLE_CYCLES - 1)) begin
            idle_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus output: forward upstream data unless this node owns the bus
  always_comb begin
    DOUT = DIN;
    case (state)
      S_ARB:   DOUT = 1'b0;
      S_DATA:  DOUT = shift_q[bit_cnt];
      S_EOM:   DOUT = EOM_PATTERN[pat_cnt];
      default: DOUT = DIN;
    endcase
  end

  assign BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_node_tx.sv
// Scoreboard bench for node_tx: each driven cycle pushes its expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_node_tx;

  localparam int unsigned ARB = 8;
  localparam int unsigned IDL = 4;
  localparam logic [2:0]  P_ACK  = 3'b100;
  localparam logic [2:0]  P_DONE = 3'b010;
  localparam logic [2:0]  P_FAIL = 3'b001;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       DIN;
  logic       DOUT;
  logic       TX_REQ;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_LAST;
  logic       TX_ACK;
  logic       TX_DONE;
  logic       TX_FAIL;
  logic       BUSY;

  int n_chk  = 0;
  int n_pass = 0;
  int win    = 0;
  string      test_name = "init";
  logic [2:0] pulse_n   = 3'b000;
  string      tag_q[$];
  logic [4:0] exp_q[$];

  node_tx #(.ARB_CYCLES(ARB), .IDLE_CYCLES(IDL)) dut (
    .CLK(CLK), .RESET(RESET), .DIN(DIN), .DOUT(DOUT),
    .TX_REQ(TX_REQ), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_LAST(TX_LAST),
    .TX_ACK(TX_ACK), .TX_DONE(TX_DONE), .TX_FAIL(TX_FAIL), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Monitor: outputs are {DOUT, BUSY, TX_ACK, TX_DONE, TX_FAIL}
  always @(negedge CLK) begin
    #1;
    if (exp_q.size() != 0) begin
      check(tag_q.pop_front(), 32'({DOUT, BUSY, TX_ACK, TX_DONE, TX_FAIL}), 32'(exp_q.pop_front()));
    end
  end

  // One bus cycle: drive inputs and queue what the DUT should show in that cycle
  task automatic cyc(input logic din, input logic req, input logic valid, input logic [7:0] data,
                     input logic last, input logic exp_dout, input logic exp_busy);
    @(negedge CLK);
    DIN = din; TX_REQ = req; TX_VALID = valid; TX_DATA = data; TX_LAST = last;
    tag_q.push_back($sformatf("%s.w%0d", test_name, win));
    exp_q.push_back({exp_dout, exp_busy, pulse_n});
    pulse_n = 3'b000;
    win++;
  endtask

  task automatic fill(input logic din, input logic exp_dout, input logic exp_busy);
    cyc(din, 1'b1, 1'b0, 8'h00, 1'b0, exp_dout, exp_busy);
  endtask

  // Full transaction from IDLE; uf = byte index presented with TX_VALID low (-1 for none)
  task automatic run_tx(input string name, input int n, input logic [7:0] b0, input logic [7:0] b1,
                        input int uf, input logic arb_din, input logic [2:0] ack_seq,
                        input logic [15:0] wpat, input int wlen);
    logic [7:0] cur;
    int ones;
    test_name = name;
    win = 0;
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int a = 0; a < ARB - 1; a++) fill(1'b1, 1'b0, 1'b1);
    cyc(arb_din, 1'b1, (uf != 0), b0, (n == 1), 1'b0, 1'b1);
    if (!arb_din) begin
      pulse_n = P_FAIL;
    end else begin
      if (uf == 0) begin
        pulse_n = P_FAIL;
      end else begin
        pulse_n = P_ACK;
        for (int j = 0; j < n; j++) begin
          cur = (j == 0) ? b0 : b1;
          for (int k = 7; k >= 0; k--) begin
            if (k == 0 && j < n - 1) cyc(1'b1, 1'b1, (uf != j + 1), b1, (j + 1 == n - 1), cur[k], 1'b1);
            else fill(1'b1, cur[k], 1'b1);
          end
          if (j < n - 1) begin
            if (uf == j + 1) begin
              pulse_n = P_FAIL;
              break;
            end
            pulse_n = P_ACK;
          end
        end
      end
      fill(1'b1, 1'b0, 1'b1);
      fill(1'b1, 1'b1, 1'b1);
      fill(1'b1, 1'b1, 1'b1);
      fill(1'b1, 1'b0, 1'b1);
      for (int i = 2; i >= 0; i--) fill(ack_seq[i], ack_seq[i], 1'b1);
      pulse_n = (ack_seq == 3'b011) ? P_DONE : P_FAIL;
    end
    ones = 0;
    for (int i = 0; i < wlen && ones < int'(IDL); i++) begin
      fill(wpat[i], wpat[i], 1'b1);
      ones = wpat[i] ? ones + 1 : 0;
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    RESET = 1'b0; DIN = 1'b0; TX_REQ = 1'b1; TX_VALID = 1'b1; TX_DATA = 8'hFF; TX_LAST = 1'b0;
    #7;
    check("rst_dout0", 32'(DOUT), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_pulses", 32'({TX_ACK, TX_DONE, TX_FAIL}), 32'd0);
    DIN = 1'b1;
    #1;
    check("rst_dout1", 32'(DOUT), 32'd1);
    @(negedge CLK);
    TX_REQ = 1'b0; TX_VALID = 1'b0; TX_DATA = 8'h00;
    RESET = 1'b1;

    // Request while DIN is low must be ignored
    test_name = "req_din0";
    win = 0;
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    run_tx("a5",     1, 8'hA5, 8'h00, -1, 1'b1, 3'b011, 16'h000F, 4);
    run_tx("lose",   1, 8'h5A, 8'h00, -1, 1'b0, 3'b011, 16'h007B, 7);
    run_tx("two",    2, 8'h3C, 8'hFF, -1, 1'b1, 3'b011, 16'h000F, 4);
    run_tx("uf2",    2, 8'h3C, 8'h81,  1, 1'b1, 3'b111, 16'h00F6, 8);
    run_tx("badack", 1, 8'h5A, 8'h00, -1, 1'b1, 3'b001, 16'h000F, 4);
    run_tx("uf0",    1, 8'h77, 8'h00,  0, 1'b1, 3'b000, 16'h000F, 4);

    // Reset during DATA while bit 4 is on the bus
    test_name = "rst_mid";
    win = 0;
    b = 8'hC3;
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int a = 0; a < ARB - 1; a++) fill(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, b, 1'b1, 1'b0, 1'b1);
    pulse_n = P_ACK;
    for (int k = 7; k >= 4; k--) fill(1'b1, b[k], 1'b1);
    #3;
    RESET = 1'b0;
    #1;
    check("rst_mid_busy", 32'(BUSY), 32'd0);
    check("rst_mid_dout1", 32'(DOUT), 32'd1);
    DIN = 1'b0;
    #1;
    check("rst_mid_dout0", 32'(DOUT), 32'd0);
    @(negedge CLK);
    #1;
    check("rst_mid_pulses", 32'({TX_ACK, TX_DONE, TX_FAIL, BUSY}), 32'd0);
    @(negedge CLK);
    TX_REQ = 1'b0; DIN = 1'b1;
    RESET = 1'b1;
    run_tx("after_rst", 1, 8'h96, 8'h00, -1, 1'b1, 3'b011, 16'h000F, 4);

    @(negedge CLK);
    #2;
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
